// File: rtl/secuenciador_pkg.sv
// Shared types for the register-bank sequencer:
// FSM states, opcode encoding and opcode field position.
package secuenciador_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } estado_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_ALU   = 3'b001,
    OP_LOAD  = 3'b010,
    OP_STORE = 3'b011,
    OP_JMP   = 3'b100,
    OP_JZ    = 3'b101,
    OP_RSV   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;

  function automatic logic usa_alu(opcode_t op);
    return op inside {OP_ALU, OP_STORE, OP_JZ};
  endfunction

  function automatic logic escribe_reg(opcode_t op);
    return op inside {OP_ALU, OP_LOAD};
  endfunction

endpackage

// File: rtl/contador_pc.sv
// Program counter: parallel load has priority over
// increment; 8-bit wraparound on increment.
module contador_pc #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       inc,
  input  logic [7:0] valor,
  output logic [7:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_RESET;
    end else if (load) begin
      pc <= valor;
    end else if (inc) begin
      pc <= pc + 8'd1;
    end
  end

endmodule

// File: rtl/secuenciador_registros.sv
// Instruction sequencer: fetch/decode/execute/writeback
// control FSM driving a register bank and ALU.
module secuenciador_registros
  import secuenciador_pkg::*;
#(
  parameter logic [7:0] PC_RESET    = 8'h00,
  parameter int         ANCHO_INSTR = 9
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Start,
  input  logic                   i_Mem_Ack,
  input  logic [ANCHO_INSTR-1:0] i_Instruccion,
  input  logic [7:0]             i_Direccion_Salto,
  input  logic                   i_Cero,
  output logic                   o_Mem_Req,
  output logic [7:0]             o_Direccion_PC,
  output logic [ANCHO_INSTR-1:0] o_Instrucciones,
  output logic                   o_Control_Registros,
  output logic                   o_Reg_WE,
  output logic                   o_Alu_Start,
  output logic                   o_Halt
);

  estado_t estado;
  opcode_t op;
  opcode_t op_lat;
  logic    vio_bajo;
  logic    pc_load;
  logic    pc_inc;
  logic    salta;

  assign op_lat = opcode_t'(o_Instrucciones[OP_MSB:OP_LSB]);

  assign salta = (op == OP_JMP) ||
                 ((op == OP_JZ) && i_Cero);

  assign pc_load = (estado == S_WRITEBACK) && salta;

  // Leaving HALT resumes at the next address.
  assign pc_inc = ((estado == S_WRITEBACK) && !salta) ||
                  ((estado == S_HALT) && vio_bajo && i_Start);

  contador_pc #(
    .PC_RESET(PC_RESET)
  ) u_pc (
    .clk  (i_Clk),
    .rst_n(i_Rst),
    .load (pc_load),
    .inc  (pc_inc),
    .valor(i_Direccion_Salto),
    .pc   (o_Direccion_PC)
  );

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      estado              <= S_IDLE;
      op                  <= OP_NOP;
      vio_bajo            <= 1'b0;
      o_Instrucciones     <= '0;
      o_Mem_Req           <= 1'b0;
      o_Reg_WE            <= 1'b0;
      o_Alu_Start         <= 1'b0;
      o_Control_Registros <= 1'b0;
      o_Halt              <= 1'b0;
    end else begin
      o_Reg_WE    <= 1'b0;
      o_Alu_Start <= 1'b0;
      unique case (estado)
        S_IDLE: begin
          if (i_Start) begin
            estado    <= S_FETCH;
            o_Mem_Req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (i_Mem_Ack) begin
            o_Instrucciones <= i_Instruccion;
            o_Mem_Req       <= 1'b0;
            estado          <= S_DECODE;
          end
        end
        S_DECODE: begin
          op          <= op_lat;
          o_Alu_Start <= usa_alu(op_lat);
          estado      <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (op == OP_HALT) begin
            o_Halt   <= 1'b1;
            vio_bajo <= 1'b0;
            estado   <= S_HALT;
          end else begin
            if (escribe_reg(op)) begin
              o_Reg_WE            <= 1'b1;
              o_Control_Registros <= (op == OP_ALU);
            end
            estado <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          o_Mem_Req <= 1'b1;
          estado    <= S_FETCH;
        end
        S_HALT: begin
          if (!i_Start) begin
            vio_bajo <= 1'b1;
          end else if (vio_bajo) begin
            o_Halt    <= 1'b0;
            o_Mem_Req <= 1'b1;
            estado    <= S_FETCH;
          end
        end
        default: estado <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_registros.sv
// Directed bench for the sequencer: ALU, LOAD with slow
// ack, JZ both ways, PC wrap, HALT restart, reset in WB.
module tb_secuenciador_registros;

  logic       clk;
  logic       rst;
  logic       start;
  logic       ack;
  logic [8:0] instr;
  logic [7:0] salto;
  logic       cero;
  logic       mem_req;
  logic [7:0] pc;
  logic [8:0] instrs;
  logic       ctrl;
  logic       we;
  logic       alu;
  logic       halt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0;

  secuenciador_registros dut (
    .i_Clk              (clk),
    .i_Rst              (rst),
    .i_Start            (start),
    .i_Mem_Ack          (ack),
    .i_Instruccion      (instr),
    .i_Direccion_Salto  (salto),
    .i_Cero             (cero),
    .o_Mem_Req          (mem_req),
    .o_Direccion_PC     (pc),
    .o_Instrucciones    (instrs),
    .o_Control_Registros(ctrl),
    .o_Reg_WE           (we),
    .o_Alu_Start        (alu),
    .o_Halt             (halt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Runs one 4-cycle instruction with immediate ack,
  // starting from FETCH; checks strobes and final PC.
  task automatic run4(input string tag,
                      input logic [8:0] ins,
                      input logic exp_alu,
                      input logic exp_we,
                      input logic [7:0] exp_pc);
    instr = ins;
    ack = 1'b1;
    step();
    chk({tag, "_instr"}, instrs, ins);
    step();
    chk({tag, "_alu"}, alu, exp_alu);
    step();
    chk({tag, "_we"}, we, exp_we);
    step();
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_req"}, mem_req, 1);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    ack = 1'b0;
    instr = '0;
    salto = 8'h00;
    cero = 1'b0;
    #12;
    chk("rst_pc", pc, 8'h00);
    chk("rst_req", mem_req, 0);
    chk("rst_instr", instrs, 0);
    chk("rst_we", we, 0);
    chk("rst_halt", halt, 0);
    chk("rst_ctrl", ctrl, 0);

    rst = 1'b1;
    step();
    step();
    chk("idle_wait", mem_req, 0);

    // ALU, immediate ack
    start = 1'b1;
    ack = 1'b1;
    instr = 9'b001_100_111;
    step();
    chk("alu_fetch_req", mem_req, 1);
    chk("alu_fetch_pc", pc, 8'h00);
    step();
    chk("alu_latch", instrs, 9'h067);
    chk("alu_req_drop", mem_req, 0);
    step();
    chk("alu_start", alu, 1);
    step();
    chk("alu_we", we, 1);
    chk("alu_ctrl", ctrl, 1);
    chk("alu_start_off", alu, 0);
    step();
    chk("alu_pc", pc, 8'h01);
    chk("alu_we_off", we, 0);
    chk("alu_refetch", mem_req, 1);

    // LOAD, ack arrives in the 4th fetch cycle
    t0 = cyc;
    ack = 1'b0;
    instr = 9'b010_001_000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("load_req_hold", mem_req, 1);
      chk("load_pc_hold", pc, 8'h01);
    end
    ack = 1'b1;
    step();
    chk("load_req_drop", mem_req, 0);
    chk("load_latch", instrs, 9'h088);
    ack = 1'b0;
    step();
    chk("load_alu", alu, 0);
    step();
    chk("load_we", we, 1);
    chk("load_ctrl", ctrl, 0);
    step();
    chk("load_pc", pc, 8'h02);
    chk("load_cycles", cyc - t0, 7);
    chk("load_ctrl_hold", ctrl, 0);

    // JZ taken and not taken
    salto = 8'h55;
    cero = 1'b1;
    run4("jz_taken", 9'b101_011_100, 1, 0, 8'h55);
    cero = 1'b0;
    run4("jz_not", 9'b101_011_100, 1, 0, 8'h56);

    // JMP to FF then NOP wraps to 00
    salto = 8'hFF;
    cero = 1'b1;
    run4("jmp", 9'b100_000_000, 0, 0, 8'hFF);
    run4("nop_wrap", 9'b000_000_000, 0, 0, 8'h00);
    run4("rsv", 9'b110_000_000, 0, 0, 8'h01);

    // HALT and restart on a rising start
    instr = 9'b111_101_000;
    step();
    step();
    chk("halt_alu", alu, 0);
    step();
    chk("halt_flag", halt, 1);
    chk("halt_req", mem_req, 0);
    chk("halt_we", we, 0);
    step();
    step();
    chk("halt_stay", halt, 1);
    chk("halt_nofetch", mem_req, 0);
    chk("halt_pc", pc, 8'h01);
    start = 1'b0;
    step();
    chk("halt_low", halt, 1);
    start = 1'b1;
    step();
    chk("halt_exit", halt, 0);
    chk("halt_refetch", mem_req, 1);
    chk("halt_pc_next", pc, 8'h02);

    // Reset asserted during ALU writeback
    instr = 9'b001_100_111;
    step();
    step();
    step();
    chk("wb_we_pre", we, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("wb_rst_we", we, 0);
    chk("wb_rst_pc", pc, 8'h00);
    chk("wb_rst_req", mem_req, 0);
    chk("wb_rst_instr", instrs, 0);
    step();
    chk("wb_rst_pc_hold", pc, 8'h00);
    start = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("post_rst_idle", mem_req, 0);
    start = 1'b1;
    step();
    chk("post_rst_fetch", mem_req, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
